if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 29 ++
 rtl/if_skid_buf.sv | 39 +++
 rtl/if_stage.sv | 128 ++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared CPU package for the instruction-fetch stage.
// Holds the instruction and PC widths, the NOP encoding, the PC increment,
// the fetch FSM state encoding and the skid-buffer entry layout.
package if_stage_pkg;

  localparam int INST_W = 32;
  localparam int PC_W   = 16;

  localparam logic [0:INST_W-1] NOP_INST = 32'h3C00_0000;
  localparam logic [0:PC_W-1]   PC_INC   = 16'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HOLD   = 2'd2,
    SQUASH = 2'd3
  } state_t;

  typedef struct packed {
    logic [0:INST_W-1] inst;
    logic [0:PC_W-1]   pc;
  } skid_entry_t;

  // Sequential fetch address; wraps modulo 2^16 by width truncation.
  function automatic logic [0:PC_W-1] pc_next(input logic [0:PC_W-1] p);
    return p + PC_INC;
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry skid buffer holding a fetched word and its PC while decode stalls.
// Ports:
//   clk, reset  rising-edge clock, synchronous active-high reset
//   load        capture din (buffer becomes full)
//   drain       entry consumed by IF/ID (buffer becomes empty)
//   clear       discard entry (taken branch)
//   din / dout  {inst, pc} entry in / out
//   full        entry is valid
module if_skid_buf
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  skid_entry_t din,
  output skid_entry_t dout,
  output logic        full
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

  // NOTE: the payload is deliberately not reset; it is only meaningful while full=1.
  always_ff @(posedge clk) begin
    if (load) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding fetch
// requests, and fills the IF/ID register. A stalled fetch parks its word in
// a one-entry skid buffer; a taken branch from decode redirects the PC and
// squashes any word still in flight.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   stall                 decode hazard; IF/ID holds its value
//   ID_br_ctrl, ID_br_pc  branch taken in decode and its target
//   imem_req, imem_addr   fetch request and byte address
//   imem_rdata, imem_valid fetch response
//   ID_inst, ID_pc, ID_valid  registered IF/ID outputs
module if_stage
  import if_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              ID_br_ctrl,
  input  logic [0:PC_W-1]   ID_br_pc,
  output logic              imem_req,
  output logic [0:PC_W-1]   imem_addr,
  input  logic [0:INST_W-1] imem_rdata,
  input  logic              imem_valid,
  output logic [0:INST_W-1] ID_inst,
  output logic [0:PC_W-1]   ID_pc,
  output logic              ID_valid
);

  state_t          state;
  logic [0:PC_W-1] pc;
  logic [0:PC_W-1] squash_addr;  // address of the request being squashed
  logic            taken;
  logic            skid_load;
  logic            skid_drain;
  logic            skid_full;
  skid_entry_t     skid_in;
  skid_entry_t     skid_out;

  // A branch only counts when the instruction in decode is real.
  assign taken = ID_br_ctrl && ID_valid;

  // While squashing, the old request stays on the bus even though the PC
  // already holds the branch target.
  assign imem_req  = !reset && ((state == FETCH) || (state == SQUASH));
  assign imem_addr = (state == SQUASH) ? squash_addr : pc;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    skid_load   = 1'b0;
    skid_drain  = 1'b0;
    skid_in.inst = imem_rdata;
    skid_in.pc   = pc;
    if (!reset && !taken) begin
      skid_load  = (state == FETCH) && imem_valid && stall;
      skid_drain = (state == HOLD) && !stall;
    end
  end

  if_skid_buf u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .drain (skid_drain),
    .clear (taken),
    .din   (skid_in),
    .dout  (skid_out),
    .full  (skid_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      squash_addr <= '0;
      ID_inst     <= NOP_INST;
      ID_pc       <= '0;
      ID_valid    <= 1'b0;
    end else if (taken) begin
      // Branch beats stall: bubble IF/ID and redirect.
      ID_inst  <= NOP_INST;
      ID_valid <= 1'b0;
      pc       <= ID_br_pc;
      if (((state == FETCH) || (state == SQUASH)) && !imem_valid) begin
        state <= SQUASH;
        if (state == FETCH) begin
          squash_addr <= pc;
        end
      end else begin
        // Any same-cycle response is dropped here.
        state <= FETCH;
      end
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
        end
        FETCH: begin
          if (imem_valid) begin
            pc <= pc_next(pc);
            if (stall) begin
              state <= HOLD;
            end else begin
              ID_inst  <= imem_rdata;
              ID_pc    <= pc;
              ID_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            ID_inst  <= skid_out.inst;
            ID_pc    <= skid_out.pc;
            ID_valid <= skid_full;
            state    <= FETCH;
          end
        end
        SQUASH: begin
          // Response to the abandoned request; PC already holds the target.
          if (imem_valid) begin
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
